// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types and flash opcodes for the quad-SPI sequencer
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        GAP
    } seq_state_t;

    typedef enum logic {
        SUB_ISSUE,
        SUB_WAIT
    } sub_state_t;

    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_QREAD = 8'h6B;
    localparam logic [7:0] CMD_QPP   = 8'h32;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

endpackage

// File: rtl/qspi_flash_sequencer.sv
// rtl/qspi_flash_sequencer.sv - splits a flash command into byte-engine jobs and owns chip select
module qspi_flash_sequencer
    import qspi_pkg::*;
#(
    parameter int ADDR_BYTES  = 3,
    parameter int DUMMY_BYTES = 1,
    parameter int LEN_W       = 8,
    parameter int SETUP_CYC   = 1,
    parameter int GAP_CYC     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_opcode,
    input  logic [31:0]      req_addr,
    input  logic             req_write,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             done,
    output logic             busy,
    output logic             cs_n,
    output logic             eng_start,
    output logic [7:0]       eng_tx,
    input  logic [7:0]       eng_rx,
    input  logic             eng_done
);

    // One counter serves setup/gap timing, address/dummy bytes and data bytes.
    localparam int CW = (LEN_W > 4) ? LEN_W : 4;

    seq_state_t       state, state_d;
    sub_state_t       sub, sub_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [7:0]       op_q;
    logic [31:0]      addr_q;
    logic             wr_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       tx_q;
    logic [7:0]       addr_byte;
    logic             accept, finish, rd_cap;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_d   = state;
        sub_d     = sub;
        cnt_d     = cnt;
        accept    = 1'b0;
        finish    = 1'b0;
        rd_cap    = 1'b0;
        eng_start = 1'b0;
        wr_ready  = 1'b0;
        eng_tx    = tx_q;
        addr_byte = 8'(addr_q >> {cnt[2:0] - 3'd1, 3'b000});
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYC);
                end
            end
            SETUP: begin
                if (cnt == CW'(1)) begin
                    state_d = CMD;
                    sub_d   = SUB_ISSUE;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == CW'(1)) state_d = IDLE;
                else               cnt_d   = cnt - CW'(1);
            end
            default: begin
                if (sub == SUB_ISSUE) begin
                    case (state)
                        CMD:     eng_tx = op_q;
                        ADDR:    eng_tx = addr_byte;
                        default: eng_tx = 8'h00;
                    endcase
                    if (state == DATA && wr_q) begin
                        wr_ready  = wr_valid;
                        eng_start = wr_valid;
                        eng_tx    = wr_data;
                    end else begin
                        eng_start = 1'b1;
                    end
                    if (eng_start) sub_d = SUB_WAIT;
                end else if (eng_done) begin
                    rd_cap = (state == DATA) && !wr_q;
                    sub_d  = SUB_ISSUE;
                    // Last byte of a phase: pick the next non-empty phase.
                    if (cnt != CW'(1)) begin
                        cnt_d = cnt - CW'(1);
                    end else if (state == CMD && ADDR_BYTES > 0) begin
                        state_d = ADDR;
                        cnt_d   = CW'(ADDR_BYTES);
                    end else if ((state == CMD || state == ADDR) && !wr_q && DUMMY_BYTES > 0) begin
                        state_d = DUMMY;
                        cnt_d   = CW'(DUMMY_BYTES);
                    end else if (state != DATA && len_q != '0) begin
                        state_d = DATA;
                        cnt_d   = CW'(len_q);
                    end else begin
                        finish  = 1'b1;
                        state_d = GAP;
                        cnt_d   = CW'(GAP_CYC);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sub      <= SUB_ISSUE;
            cnt      <= '0;
            op_q     <= 8'h00;
            addr_q   <= 32'h0;
            wr_q     <= 1'b0;
            len_q    <= '0;
            tx_q     <= 8'h00;
            cs_n     <= 1'b1;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            state    <= state_d;
            sub      <= sub_d;
            cnt      <= cnt_d;
            done     <= finish;
            rd_valid <= rd_cap;
            if (rd_cap)    rd_data <= eng_rx;
            if (eng_start) tx_q    <= eng_tx;
            if (accept) begin
                op_q   <= req_opcode;
                addr_q <= req_addr;
                wr_q   <= req_write;
                len_q  <= req_len;
                cs_n   <= 1'b0;
            end else if (finish) begin
                cs_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// tb/tb_qspi_flash_sequencer.sv - randomized self-checking bench for qspi_flash_sequencer
module tb_qspi_flash_sequencer;
    import qspi_pkg::*;

    localparam int AB = 3, DB = 1, LW = 8, SC = 1, GC = 2;

    logic clk = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [7:0] req_opcode = 8'h00;
    logic [31:0] req_addr = 32'h0;
    logic [LW-1:0] req_len = '0;
    logic wr_valid = 1'b0, wr_ready, rd_valid, done, busy, cs_n, eng_start, eng_done = 1'b0;
    logic [7:0] wr_data = 8'h00, rd_data, eng_tx, eng_rx = 8'h00;
    logic req_valid0 = 1'b0, req_ready0, wr_ready0, rd_valid0, done0, busy0, cs_n0, eng_start0;
    logic eng_done0 = 1'b0;
    logic [7:0] rd_data0, eng_tx0;

    qspi_flash_sequencer #(.ADDR_BYTES(AB), .DUMMY_BYTES(DB), .LEN_W(LW), .SETUP_CYC(SC), .GAP_CYC(GC)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_write(req_write), .req_len(req_len), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy), .cs_n(cs_n),
        .eng_start(eng_start), .eng_tx(eng_tx), .eng_rx(eng_rx), .eng_done(eng_done));

    qspi_flash_sequencer #(.ADDR_BYTES(0), .DUMMY_BYTES(0), .LEN_W(LW), .SETUP_CYC(SC), .GAP_CYC(GC)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_write(req_write), .req_len(req_len), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready0), .rd_valid(rd_valid0), .rd_data(rd_data0), .done(done0), .busy(busy0), .cs_n(cs_n0),
        .eng_start(eng_start0), .eng_tx(eng_tx0), .eng_rx(eng_rx), .eng_done(eng_done0));

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    logic [7:0] tx_log[$], rd_log[$], rx_log[$], wr_src[$], rx_plan[$];
    int start_cyc[$], done_cyc[$], done_log[$], acc_cyc[$], fall_cyc[$], rise_cyc[$];
    int cs_bad, hold_bad, stall_starts, wr_cnt, wr_idx, stall_at, stall_left, eng_lat;
    bit eng_pend = 0, spur_mode = 0, spur_now = 0, spur_next = 0, stalling = 0;
    logic cs_prev = 1'b1;
    logic [7:0] tx_hold;

    initial forever begin @(posedge clk); cyc++; end

    // Engine model: completes each started byte after 0..2 extra cycles.
    initial forever begin
        @(posedge clk); #1;
        eng_done = 1'b0;
        if (spur_next || spur_now) begin eng_done = 1'b1; eng_rx = 8'hEE; spur_next = 0; end
        if (eng_pend) begin
            if (eng_lat == 0) begin
                eng_done = 1'b1;
                eng_rx = (rx_plan.size() > 0) ? rx_plan.pop_front() : 8'($urandom);
                rx_log.push_back(eng_rx);
                done_cyc.push_back(cyc);
                eng_pend = 0;
                if (spur_mode) spur_next = 1;
            end else eng_lat--;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        stalling = 0;
        if (wr_idx < wr_src.size()) begin
            if (wr_idx == stall_at && stall_left > 0) begin
                wr_valid = 1'b0; stall_left--; stalling = 1;
            end else begin
                wr_valid = 1'b1; wr_data = wr_src[wr_idx];
            end
        end else wr_valid = 1'b0;
    end

    initial forever begin
        @(negedge clk);
        if (eng_start) begin
            tx_log.push_back(eng_tx); start_cyc.push_back(cyc);
            if (cs_n) cs_bad++;
            if (stalling) stall_starts++;
            eng_pend = 1; eng_lat = $urandom_range(0, 2); tx_hold = eng_tx;
        end else if (eng_pend && eng_tx !== tx_hold) hold_bad++;
        if (rd_valid) rd_log.push_back(rd_data);
        if (done) done_log.push_back(cyc);
        if (wr_ready) begin wr_cnt++; wr_idx++; end
        if (req_valid && req_ready) acc_cyc.push_back(cyc);
        if (cs_n !== cs_prev) begin
            if (cs_n) rise_cyc.push_back(cyc); else fall_cyc.push_back(cyc);
            cs_prev = cs_n;
        end
    end

    task automatic clear_logs();
        tx_log.delete(); rd_log.delete(); rx_log.delete(); start_cyc.delete(); done_cyc.delete();
        done_log.delete(); acc_cyc.delete(); fall_cyc.delete(); rise_cyc.delete();
        cs_bad = 0; hold_bad = 0; stall_starts = 0; wr_cnt = 0; wr_idx = 0; stall_left = 0; stall_at = 1;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic wr, input int len,
                           input int stall, input bit spur);
        logic [7:0] exp_tx[$];
        int t_acc, n, d, rdy;
        bit ok;
        clear_logs(); stall_left = stall; spur_mode = spur;
        @(posedge clk); #1;
        req_opcode = op; req_addr = addr; req_write = wr; req_len = LW'(len); req_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (req_ready) begin ok = 1; break; end end
        t_acc = cyc;
        @(posedge clk); #1; req_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (done_log.size() > 0 && req_ready) begin ok = 1; break; end
        end
        rdy = cyc; spur_mode = 0;
        tests++; if (!ok) begin fails++; $display("FAIL txn_timeout op=%0h: no completion seen", op); end
        exp_tx.push_back(op);
        for (int i = AB - 1; i >= 0; i--) exp_tx.push_back(addr[8*i +: 8]);
        if (!wr) for (int i = 0; i < DB; i++) exp_tx.push_back(8'h00);
        for (int i = 0; i < len; i++) exp_tx.push_back(wr ? wr_src[i] : 8'h00);
        n = exp_tx.size();
        tests++; if (tx_log.size() != n) begin fails++; $display("FAIL tx_count op=%0h got %0d want %0d", op, tx_log.size(), n); end
        for (int i = 0; i < n && i < tx_log.size(); i++) begin
            tests++; if (tx_log[i] !== exp_tx[i]) begin fails++; $display("FAIL tx_byte[%0d] got %0h want %0h", i, tx_log[i], exp_tx[i]); end
        end
        if (!wr) begin
            tests++; if (rd_log.size() != len) begin fails++; $display("FAIL rd_count got %0d want %0d", rd_log.size(), len); end
            for (int i = 0; i < len && i < rd_log.size() && rx_log.size() >= n; i++) begin
                tests++; if (rd_log[i] !== rx_log[n-len+i]) begin fails++; $display("FAIL rd_byte[%0d] got %0h want %0h", i, rd_log[i], rx_log[n-len+i]); end
            end
        end
        d = (done_cyc.size() > 0) ? done_cyc[done_cyc.size()-1] : -100;
        tests++; if (done_log.size() != 1 || done_log[0] != d + 1) begin fails++; $display("FAIL done_pulse count %0d at %0d want 1 at %0d", done_log.size(), (done_log.size() > 0) ? done_log[0] : -1, d + 1); end
        tests++; if (fall_cyc.size() != 1 || fall_cyc[0] != t_acc + 1) begin fails++; $display("FAIL cs_fall count %0d at %0d want 1 at %0d", fall_cyc.size(), (fall_cyc.size() > 0) ? fall_cyc[0] : -1, t_acc + 1); end
        tests++; if (rise_cyc.size() != 1 || rise_cyc[0] != d + 1) begin fails++; $display("FAIL cs_rise count %0d at %0d want 1 at %0d", rise_cyc.size(), (rise_cyc.size() > 0) ? rise_cyc[0] : -1, d + 1); end
        tests++; if (start_cyc.size() == 0 || start_cyc[0] != t_acc + 1 + SC) begin fails++; $display("FAIL first_start got %0d want %0d", (start_cyc.size() > 0) ? start_cyc[0] : -1, t_acc + 1 + SC); end
        for (int i = 1; i < start_cyc.size() && i <= done_cyc.size(); i++) begin
            tests++;
            if (stall > 0 ? (start_cyc[i] <= done_cyc[i-1]) : (start_cyc[i] != done_cyc[i-1] + 1)) begin
                fails++; $display("FAIL start_gap[%0d] got %0d want %0d", i, start_cyc[i], done_cyc[i-1] + 1);
            end
        end
        tests++; if (rdy != d + 1 + GC) begin fails++; $display("FAIL ready_return got %0d want %0d", rdy, d + 1 + GC); end
        tests++; if (cs_bad != 0 || hold_bad != 0 || stall_starts != 0) begin fails++; $display("FAIL protocol cs_bad=%0d hold_bad=%0d stall_starts=%0d want 0", cs_bad, hold_bad, stall_starts); end
        tests++; if (wr_cnt != (wr ? len : 0)) begin fails++; $display("FAIL wr_ready_count got %0d want %0d", wr_cnt, wr ? len : 0); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || cs_n !== 1'b1 || busy !== 1'b0 || eng_start !== 1'b0 || eng_tx !== 8'h00 ||
            rd_valid !== 1'b0 || rd_data !== 8'h00 || done !== 1'b0 || wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got ready=%b cs_n=%b busy=%b start=%b tx=%h rdv=%b rd=%h done=%b wrr=%b want 1 1 0 0 00 0 00 0 0",
                     req_ready, cs_n, busy, eng_start, eng_tx, rd_valid, rd_data, done, wr_ready);
        end
        @(posedge clk); #2; reset = 1'b1;
    endtask

    task automatic test_quad_read();
        wr_src.delete();
        rx_plan = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3C};
        run_txn(CMD_QREAD, 32'h0012_3456, 1'b0, 2, 0, 0);
        tests++; if (rd_log.size() != 2 || rd_log[0] !== 8'hA5 || rd_log[1] !== 8'h3C) begin fails++; $display("FAIL quad_read_data got %0d bytes want A5 3C", rd_log.size()); end
    endtask

    task automatic test_write_stall();
        wr_src = '{8'h11, 8'h22, 8'h33};
        run_txn(CMD_QPP, 32'h0000_0100, 1'b1, 3, 5, 0);
        wr_src.delete();
    endtask

    task automatic test_zero_len();
        int starts = 0, dones = 0, done_c = -1, d0 = -100;
        bit sched = 0;
        logic [7:0] tx0 = 8'h00;
        @(posedge clk); #1;
        req_opcode = CMD_WREN; req_addr = 32'h0; req_write = 1'b1; req_len = '0; req_valid0 = 1'b1;
        @(posedge clk); #1; req_valid0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (eng_start0) begin starts++; tx0 = eng_tx0; sched = 1; end
            if (done0) begin dones++; done_c = cyc; end
            @(posedge clk); #1;
            eng_done0 = sched;
            if (sched) d0 = cyc;
            sched = 0;
        end
        tests++; if (starts != 1 || tx0 !== CMD_WREN) begin fails++; $display("FAIL zero_len_start got %0d starts tx %h want 1 tx 06", starts, tx0); end
        tests++; if (dones != 1 || done_c != d0 + 1) begin fails++; $display("FAIL zero_len_done got %0d at %0d want 1 at %0d", dones, done_c, d0 + 1); end
        tests++; if (cs_n0 !== 1'b1 || req_ready0 !== 1'b1) begin fails++; $display("FAIL zero_len_idle got cs_n=%b ready=%b want 1 1", cs_n0, req_ready0); end
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        clear_logs();
        @(posedge clk); #1;
        req_opcode = CMD_QREAD; req_addr = $urandom; req_write = 1'b0; req_len = 8'd4; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin @(negedge clk); #1; if (start_cyc.size() >= 3) begin ok = 1; break; end end
        tests++; if (!ok) begin fails++; $display("FAIL reset_mid_reach got %0d starts want 3", start_cyc.size()); end
        @(posedge clk); #3; reset = 1'b0; eng_pend = 0;
        #1;
        tests++; if (cs_n !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL reset_mid_abort got cs_n=%b busy=%b ready=%b want 1 0 1", cs_n, busy, req_ready); end
        repeat (3) begin @(negedge clk); #1; end
        tests++; if (done_log.size() != 0) begin fails++; $display("FAIL reset_mid_done got %0d pulses want 0", done_log.size()); end
        @(posedge clk); #2; reset = 1'b1; eng_pend = 0;
        run_txn(CMD_RDSR, $urandom, 1'b0, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        bit ok = 0;
        clear_logs();
        @(posedge clk); #1;
        req_opcode = CMD_QREAD; req_addr = $urandom; req_write = 1'b0; req_len = 8'd1; req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin @(negedge clk); #1; if (acc_cyc.size() >= 1) break; end
        @(posedge clk); #1; req_opcode = CMD_RDSR;
        for (int k = 0; k < 500; k++) begin @(negedge clk); #1; if (acc_cyc.size() >= 2) break; end
        @(posedge clk); #1; req_valid = 1'b0;
        for (int k = 0; k < 500; k++) begin @(negedge clk); #1; if (done_log.size() >= 2 && req_ready) begin ok = 1; break; end end
        tests++; if (!ok || acc_cyc.size() != 2) begin fails++; $display("FAIL b2b_complete got %0d accepts %0d dones want 2 2", acc_cyc.size(), done_log.size()); end
        if (acc_cyc.size() == 2 && done_log.size() >= 1 && rise_cyc.size() >= 1 && fall_cyc.size() >= 2) begin
            tests++; if (acc_cyc[1] != done_log[0] + GC) begin fails++; $display("FAIL b2b_accept got %0d want %0d", acc_cyc[1], done_log[0] + GC); end
            tests++; if (fall_cyc[1] - rise_cyc[0] != GC + 1) begin fails++; $display("FAIL b2b_cs_high got %0d want %0d", fall_cyc[1] - rise_cyc[0], GC + 1); end
        end
        tests++; if (tx_log.size() != 2 * (2 + AB + DB) || tx_log[2 + AB + DB] !== CMD_RDSR) begin fails++; $display("FAIL b2b_second_cmd got %0d bytes want %0d with opcode 05", tx_log.size(), 2 * (2 + AB + DB)); end
    endtask

    task automatic test_spurious();
        clear_logs();
        @(posedge clk); spur_now = 1;
        repeat (3) begin
            @(negedge clk);
            tests++; if (busy !== 1'b0 || cs_n !== 1'b1 || eng_start !== 1'b0 || rd_valid !== 1'b0) begin fails++; $display("FAIL spur_idle got busy=%b cs_n=%b start=%b rdv=%b want 0 1 0 0", busy, cs_n, eng_start, rd_valid); end
        end
        spur_now = 0;
        @(posedge clk); #2;
        wr_src.delete();
        run_txn(CMD_QREAD, $urandom, 1'b0, 3, 0, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic w;
            int len;
            w = 1'($urandom);
            len = w ? $urandom_range(0, 6) : $urandom_range(1, 6);
            wr_src.delete();
            if (w) for (int i = 0; i < len; i++) wr_src.push_back(8'($urandom));
            run_txn(8'($urandom), $urandom, w, len, (w && len > 1) ? $urandom_range(0, 4) : 0, 1'($urandom));
        end
        wr_src.delete();
    endtask

    initial begin
        test_reset();
        test_quad_read();
        test_write_stall();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
